// File: rtl/clock_divider_bank.sv
// clock_divider_bank: shared prescaler feeding NCH independent base-tick dividers.
// Define CLKDIV_RUNTIME_LOAD_EN to enable runtime divisor loads; otherwise divisors are fixed at DIV_INIT.
module clock_divider_bank #(
    parameter int                  CLK_HZ   = 50000000,
    parameter int                  BASE_HZ  = 100,
    parameter int                  NCH      = 4,
    parameter int                  DIVW     = 16,
    parameter logic [NCH*DIVW-1:0] DIV_INIT = {NCH{16'd100}},
    localparam int                 CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            CLK_50MHz,
    input  logic            rst,
    input  logic            en,
    input  logic            sync_clr,
    input  logic            ld_valid,
    input  logic [CHW-1:0]  ld_ch,
    input  logic [DIVW-1:0] ld_div,
    output logic            ld_ready,
    output logic            base_tick,
    output logic [NCH-1:0]  tick,
    output logic [NCH-1:0]  clk_out
);

    localparam int PRE = CLK_HZ / BASE_HZ;
    localparam int PW  = (PRE > 1) ? $clog2(PRE) : 1;

    generate
        if ((CLK_HZ % BASE_HZ) != 0 || PRE < 2) begin : g_cfg_check
            $error("clock_divider_bank: CLK_HZ must be a multiple of BASE_HZ with PRE >= 2");
        end
    endgenerate

    logic [PW-1:0] r_pre;
    logic          r_base_tick;
    logic          w_adv;

    always_ff @(posedge CLK_50MHz or posedge rst) begin
        if (rst) begin
            r_pre       <= '0;
            r_base_tick <= 1'b0;
        end else if (sync_clr) begin
            r_pre       <= '0;
            r_base_tick <= 1'b0;
        end else if (en && r_pre == PW'(PRE - 1)) begin
            r_pre       <= '0;
            r_base_tick <= 1'b1;
        end else begin
            if (en) begin
                r_pre <= r_pre + PW'(1);
            end
            r_base_tick <= 1'b0;
        end
    end

    assign base_tick = r_base_tick;
    assign w_adv     = en & r_base_tick;

`ifdef CLKDIV_RUNTIME_LOAD_EN
    logic [NCH-1:0] w_pending;
    logic           w_ch_ok;
    logic           w_accept;

    // Requests to channels that do not exist are acknowledged and discarded.
    assign w_ch_ok  = 32'(ld_ch) < NCH;
    assign ld_ready = w_ch_ok ? ~w_pending[ld_ch] : 1'b1;
    assign w_accept = ld_valid & ld_ready & w_ch_ok;
`else
    logic w_unused_ld;

    assign ld_ready    = 1'b0;
    assign w_unused_ld = ^{ld_valid, ld_ch, ld_div};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DIVW-1:0] w_div;
            logic [DIVW-1:0] r_cnt;
            logic            r_tick;
            logic            r_clk;
            logic            w_wrap;

            assign w_wrap = w_adv && (w_div != '0) && (r_cnt == w_div - DIVW'(1));

`ifdef CLKDIV_RUNTIME_LOAD_EN
            logic [DIVW-1:0] r_div;
            logic [DIVW-1:0] r_shadow;
            logic            r_pend;

            // A new divisor only lands on a period boundary so no period is ever truncated.
            always_ff @(posedge CLK_50MHz or posedge rst) begin
                if (rst) begin
                    r_div    <= DIV_INIT[gi*DIVW +: DIVW];
                    r_shadow <= '0;
                    r_pend   <= 1'b0;
                end else if (w_accept && ld_ch == CHW'(gi)) begin
                    r_shadow <= ld_div;
                    r_pend   <= 1'b1;
                end else if (r_pend && (sync_clr || w_div == '0 || w_wrap)) begin
                    r_div  <= r_shadow;
                    r_pend <= 1'b0;
                end
            end

            assign w_div          = r_div;
            assign w_pending[gi]  = r_pend;
`else
            assign w_div = DIV_INIT[gi*DIVW +: DIVW];
`endif

            always_ff @(posedge CLK_50MHz or posedge rst) begin
                if (rst) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                    r_clk  <= 1'b0;
                end else if (sync_clr) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                    r_clk  <= 1'b0;
                end else if (!en) begin
                    r_tick <= 1'b0;
                end else if (w_div == '0) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                    r_clk  <= 1'b0;
                end else if (w_div == DIVW'(1)) begin
                    r_cnt  <= '0;
                    r_tick <= r_base_tick;
                    r_clk  <= r_base_tick;
                end else begin
                    r_tick <= 1'b0;
                    if (r_base_tick) begin
                        if (w_wrap) begin
                            r_cnt  <= '0;
                            r_tick <= 1'b1;
                            r_clk  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + DIVW'(1);
                            // Level form keeps the wave correct even right after a divisor change.
                            r_clk <= (r_cnt + DIVW'(1)) >= (w_div >> 1);
                        end
                    end
                end
            end

            assign tick[gi]    = r_tick;
            assign clk_out[gi] = r_clk;
        end
    endgenerate

endmodule

// File: tb/tb_clock_divider_bank.sv
// Randomised bench for clock_divider_bank against an event-level model of the divider rules.
// Works with or without CLKDIV_RUNTIME_LOAD_EN defined.
module tb_clock_divider_bank;

    localparam int NCH  = 4;
    localparam int DIVW = 16;
    localparam int PRE  = 10;
    localparam logic [NCH*DIVW-1:0] INIT = {16'd1, 16'd0, 16'd5, 16'd4};
`ifdef CLKDIV_RUNTIME_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    logic            clk      = 1'b0;
    logic            rst      = 1'b1;
    logic            en       = 1'b0;
    logic            sync_clr = 1'b0;
    logic            ld_valid = 1'b0;
    logic [1:0]      ld_ch    = 2'd0;
    logic [DIVW-1:0] ld_div   = '0;
    logic            ld_ready;
    logic            base_tick;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  clk_out;

    int total = 0;
    int bad   = 0;

    clock_divider_bank #(
        .CLK_HZ   (1000),
        .BASE_HZ  (100),
        .NCH      (NCH),
        .DIVW     (DIVW),
        .DIV_INIT (INIT)
    ) dut (
        .CLK_50MHz (clk),
        .rst       (rst),
        .en        (en),
        .sync_clr  (sync_clr),
        .ld_valid  (ld_valid),
        .ld_ch     (ld_ch),
        .ld_div    (ld_div),
        .ld_ready  (ld_ready),
        .base_tick (base_tick),
        .tick      (tick),
        .clk_out   (clk_out)
    );

    always #5 clk = ~clk;

    // Reference model state: divisor, phase within period, pending shadow.
    int             m_div [NCH];
    int             m_ph  [NCH];
    int             m_shd [NCH];
    bit             m_pend[NCH];
    int             m_n;
    bit             m_base;
    bit [NCH-1:0]   m_tick;
    bit [NCH-1:0]   m_clk;
    int             edge_no;
    int             first_base;
    int             first_tick0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_ready(input int ch);
        return LOAD_EN ? !m_pend[ch] : 1'b0;
    endfunction

    task automatic model_reset();
        logic [NCH*DIVW-1:0] init_v;
        init_v = INIT;
        m_n    = 0;
        m_base = 1'b0;
        m_tick = '0;
        m_clk  = '0;
        for (int i = 0; i < NCH; i++) begin
            m_div[i]  = int'(init_v[i*DIVW +: DIVW]);
            m_ph[i]   = 0;
            m_shd[i]  = 0;
            m_pend[i] = 1'b0;
        end
        edge_no     = 0;
        first_base  = -1;
        first_tick0 = -1;
    endtask

    task automatic model_step(input bit en_v, input bit clr_v, input bit lv, input int lch, input int ldiv);
        bit acc;
        bit adv;
        bit wrap;
        acc = LOAD_EN && lv && !m_pend[lch];
        if (clr_v) begin
            m_n    = 0;
            m_base = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_ph[i]   = 0;
                m_tick[i] = 1'b0;
                m_clk[i]  = 1'b0;
                if (m_pend[i]) begin
                    m_div[i]  = m_shd[i];
                    m_pend[i] = 1'b0;
                end
            end
        end else begin
            adv = en_v && m_base;
            if (en_v) begin
                m_n++;
                m_base = (m_n % PRE) == 0;
            end else begin
                m_base = 1'b0;
            end
            for (int i = 0; i < NCH; i++) begin
                wrap = 1'b0;
                if (en_v) begin
                    if (m_div[i] == 0) begin
                        m_ph[i]  = 0;
                        m_clk[i] = 1'b0;
                    end else begin
                        if (adv) begin
                            m_ph[i] = (m_ph[i] + 1) % m_div[i];
                            wrap    = (m_ph[i] == 0);
                        end
                        if (m_div[i] == 1)
                            m_clk[i] = adv;
                        else if (adv)
                            m_clk[i] = m_ph[i] >= (m_div[i] / 2);
                    end
                end
                m_tick[i] = wrap;
                if (m_pend[i] && (m_div[i] == 0 || wrap)) begin
                    m_div[i]  = m_shd[i];
                    m_pend[i] = 1'b0;
                end
            end
        end
        if (acc) begin
            m_shd[lch]  = ldiv;
            m_pend[lch] = 1'b1;
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit en_v, input bit clr_v, input bit lv, input int lch, input int ldiv);
        en       = en_v;
        sync_clr = clr_v;
        ld_valid = lv;
        ld_ch    = 2'(lch);
        ld_div   = DIVW'(ldiv);
        #1;
        chk($sformatf("ld_ready@%0d", edge_no), 32'(ld_ready), 32'(m_ready(lch)));
        if (lv)
            $display("load edge=%0d ch=%0d div=%0d ready=%0b", edge_no, lch, ldiv, ld_ready);
        @(posedge clk);
        model_step(en_v, clr_v, lv, lch, ldiv);
        edge_no++;
        @(negedge clk);
        chk($sformatf("base_tick@%0d", edge_no), 32'(base_tick), 32'(m_base));
        chk($sformatf("tick@%0d", edge_no), 32'(tick), 32'(m_tick));
        chk($sformatf("clk_out@%0d", edge_no), 32'(clk_out), 32'(m_clk));
        if (first_base < 0 && base_tick)
            first_base = edge_no;
        if (first_tick0 < 0 && tick[0])
            first_tick0 = edge_no;
    endtask

    task automatic rand_step();
        step($urandom_range(0, 9) != 0, $urandom_range(0, 299) == 0,
             $urandom_range(0, 19) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_base_tick", 32'(base_tick), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'(LOAD_EN));
        model_reset();
        rst = 1'b0;

        $display("phase: free run");
        repeat (100) step(1, 0, 0, 0, 0);
        chk("first_base_edge", 32'(first_base), 32'd10);
        chk("first_tick0_edge", 32'(first_tick0), 32'd41);

        $display("phase: en low 25 cycles");
        repeat (7) step(1, 0, 0, 0, 0);
        repeat (25) step(0, 0, 0, 0, 0);
        repeat (60) step(1, 0, 0, 0, 0);

        $display("phase: load ch1=3 then retry while pending");
        step(1, 0, 1, 1, 3);
        step(1, 0, 1, 1, 7);
        repeat (150) step(1, 0, 0, 0, 0);

        $display("phase: load disabled ch2=2");
        step(1, 0, 1, 2, 2);
        repeat (100) step(1, 0, 0, 0, 0);

        $display("phase: sync_clr");
        repeat (13) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        repeat (60) step(1, 0, 0, 0, 0);

        $display("phase: random");
        repeat (1500) rand_step();

        $display("phase: async reset between edges");
        step(1, 0, 0, 0, 0);
        #3 rst = 1'b1;
        #1;
        chk("arst_base_tick", 32'(base_tick), 32'd0);
        chk("arst_tick", 32'(tick), 32'd0);
        chk("arst_clk_out", 32'(clk_out), 32'd0);
        chk("arst_ld_ready", 32'(ld_ready), 32'(LOAD_EN));
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        repeat (60) step(1, 0, 0, 0, 0);
        chk("post_rst_tick0_edge", 32'(first_tick0), 32'd41);
        repeat (400) rand_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Parametrised multi-channel clock divider driven from the 50 MHz board clock. A shared prescaler produces a base-rate tick. NCH independent channel dividers count base ticks and each emits a single-cycle tick and a registered square-wave enable. Channel divisors are runtime-loadable, and a new divisor takes effect only at the channel's next wrap, so no period is ever cut short. The block replaces fixed 100 Hz / 1 Hz dividers wherever timer and display logic needs several slow rates.

## Interface
Parameters:
- CLK_HZ, 50000000, input clock frequency
- BASE_HZ, 100, prescaler tick rate; PRE = CLK_HZ/BASE_HZ
- NCH, 4, channel count (1..16)
- DIVW, 16, divisor width
- DIV_INIT, {NCH{16'd100}}, NCH×DIVW reset divisors; channel i occupies bits [i*DIVW +: DIVW]

Ports:
- CLK_50MHz  in  1  clock; all logic is on the rising edge
- rst  in  1  asynchronous reset, active-high
- en  in  1  run enable
- sync_clr  in  1  synchronous realign/clear
- ld_valid  in  1  divisor load request
- ld_ch  in  max(1,$clog2(NCH))  target channel
- ld_div  in  DIVW  new divisor
- ld_ready  out  1  load accepted when high with ld_valid
- base_tick  out  1  one-cycle pulse at BASE_HZ
- tick  out  NCH  one-cycle pulse per channel wrap
- clk_out  out  NCH  registered square wave per channel

## Operation
- Elaboration fails if CLK_HZ % BASE_HZ != 0 or PRE < 2.
- Prescaler p counts 0..PRE-1 while en=1. On an edge with p==PRE-1 and en=1: p<=0, base_tick<=1. On all other edges base_tick<=0.
- Each channel has an active divisor D, a count c, a shadow divisor and a pending flag. The channel advances only on cycles where registered base_tick==1.
- Advance with c==D-1: c<=0, tick[i]<=1, clk_out[i]<=0. Otherwise c<=c+1, and clk_out[i]<=1 when c+1==D>>1.
  - High time is D-(D>>1) base periods; low time is D>>1. Example: D=5 gives 3 high, 2 low.
- D==1: tick[i] and clk_out[i] both pulse the cycle after every base_tick.
- D==0: channel disabled. c=0; tick[i] and clk_out[i] stay 0.
- Load handshake: accept = ld_valid & ld_ready.
  - Accept writes the shadow and sets pending[ld_ch].
  - ld_ready = ~pending[ld_ch]. Out-of-range ld_ch gives ld_ready=1, and the load is dropped.
  - A pending divisor is copied into D, and pending cleared, at the channel's next wrap, on sync_clr, or immediately if the active D==0.
- en=0: p and all c hold; base_tick and tick are 0; clk_out holds.
- sync_clr=1: p<=0, all c<=0, base_tick/tick/clk_out<=0, and all pending shadows are applied. It has priority over en. A load in the same cycle is accepted and stays pending.

## Timing
- Reset values: p=0, c=0, base_tick=0, tick=0, clk_out=0, ld_ready=1, D=DIV_INIT, pending=0.
- The first base_tick is high on the PRE-th rising edge after rst deasserts, with en=1 throughout. After sync_clr deasserts it is likewise high on the PRE-th edge.
- tick[i] lags its triggering base_tick by exactly 1 cycle. Period = PRE×D cycles.
- Reset applies asynchronously at any point, including mid-load or mid-period.
- A load accepted on the same edge as the channel's wrap becomes pending; it applies at the following wrap.

## Configuration
- CLKDIV_RUNTIME_LOAD_EN defined: load interface as described.
- CLKDIV_RUNTIME_LOAD_EN undefined:
  - ld_valid, ld_ch and ld_div are ignored; ld_ready is tied 0.
  - D is constant DIV_INIT; shadow and pending logic is removed.

## Test plan
Common parameters: CLK_HZ=1000, BASE_HZ=100 (PRE=10), NCH=4, DIV_INIT ch0=4, ch1=5, ch2=0, ch3=1.
- Release rst, en=1 -> base_tick on edges 10, 20, 30…; tick[0] on edges 41, 81; clk_out[0] high over edges 21..40 (2 base periods), low 2; tick[3] pulses the cycle after every base_tick; tick[2]/clk_out[2] stay 0.
- en=0 for 25 cycles mid-period -> no base_tick/tick; clk_out held; the next tick[0] is exactly 25 cycles late.
- Load ch1=3 mid-count (macro on) -> ld_ready low for ch1 until its wrap; subsequent tick[1] period is 30 cycles; a second load to ch1 while pending is not accepted.
- Load ch2=2 while disabled -> applies immediately; tick[2] every 20 cycles; clk_out[2] 1 high / 1 low base period.
- sync_clr one cycle mid-period -> all outputs 0 next edge; base_tick PRE edges after deassert; channels realigned.
- Assert rst between clock edges -> all outputs 0 immediately, D back to DIV_INIT; without the macro, ld_ready stays 0 and loads are ignored.
